// File: rtl/i4001_master_if.sv
// i4001_master_if
// Bundles the CPU-side request/response handshake and the memory pin bus
// of the i4001 memory initiator.
//   master modport : the initiator (drives req_ready, rsp_*, wr_err, pc, mem_we/addr/din)
//   slave  modport : the environment (drives req*, mem_dout)
// Parameters: ADDR_W (memory address width), DATA_W (memory word width).
interface i4001_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic              req;
    logic              req_we;
    logic              req_seq;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              wr_err;
    logic [ADDR_W-1:0] pc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  req, req_we, req_seq, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_data, wr_err, pc, mem_we, mem_addr, mem_din
    );

    modport slave (
        output req, req_we, req_seq, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_data, wr_err, pc, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/i4001_master.sv
// i4001_master
// Bus initiator for the i4001 program/data memory. Accepts one read or
// write request at a time from the CPU core, sequences WE/address/data to
// a block RAM, absorbs the RAM read latency and returns read data with a
// one-cycle valid pulse. An internal program counter supplies the address
// for sequential fetches and is post-incremented by every accepted request.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : i4001_master_if.master (request/response handshake + memory pins)
// Parameters: ADDR_W, DATA_W, RD_LATENCY (1, or 2 when the RAM output register is used).
// Optional feature macro: I4001_RDBACK_EN -- every write is re-read and
// compared; a mismatch pulses wr_err for one cycle.
module i4001_master #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input logic             CLK,
    input logic             RST_N,
    i4001_master_if.master  bus
);

    localparam logic [1:0] LAT = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RESP     = 3'd3
`ifdef I4001_RDBACK_EN
        ,
        S_VFY_WAIT = 3'd4,
        S_VFY      = 3'd5
`endif
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_we;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    state_t            w_state_nxt;
    logic [1:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_din_nxt;
    logic              w_mem_we_nxt;
    logic              w_req_ready_nxt;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] w_rsp_data_nxt;
    logic [ADDR_W-1:0] w_sel_addr;

`ifdef I4001_RDBACK_EN
    logic              r_wr_err;
    logic              w_wr_err_nxt;
`endif

    // Sequential fetches take the address from pc, explicit accesses from the core.
    assign w_sel_addr = bus.req_seq ? r_pc : bus.req_addr;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pc_nxt        = r_pc;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_din_nxt   = r_mem_din;
        w_mem_we_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
`ifdef I4001_RDBACK_EN
        w_wr_err_nxt    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.req && r_req_ready) begin
                    w_mem_addr_nxt = w_sel_addr;
                    w_pc_nxt       = w_sel_addr + ADDR_W'(1);
                    if (bus.req_we) begin
                        w_mem_din_nxt = bus.req_wdata;
                        w_mem_we_nxt  = 1'b1;
                        w_state_nxt   = S_WR;
                    end else begin
                        // Counter runs LAT..0 so capture lands LAT cycles after the address.
                        w_cnt_nxt     = LAT;
                        w_state_nxt   = S_RD_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
`ifdef I4001_RDBACK_EN
                // Address is still on the bus; the re-read is issued in the first wait cycle.
                w_cnt_nxt   = LAT - 2'd1;
                w_state_nxt = S_VFY_WAIT;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_RD_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_rsp_data_nxt  = bus.mem_dout;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
`ifdef I4001_RDBACK_EN
            S_VFY_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_VFY;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            S_VFY: begin
                // mem_din still holds the data that was written.
                w_wr_err_nxt = (bus.mem_dout != r_mem_din);
                w_state_nxt  = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_pc        <= '0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_we    <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pc        <= w_pc_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_din   <= w_mem_din_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

`ifdef I4001_RDBACK_EN
    // Read-back mismatch pulse register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_err_nxt;
        end
    end

    assign bus.wr_err = r_wr_err;
`else
    assign bus.wr_err = 1'b0;
`endif

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.pc        = r_pc;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_din   = r_mem_din;

endmodule
